stage_queue: RTL and testbench

Parametrised multi-lane decoupling queue that replaces the single-entry stall/flush pipeline registers between in-order front-end stages (fetch→decode, decode→renaming). Each cycle it accepts up to `LANES` entries with an arbitrary valid mask, compacts them in lane order, and presents up to `LANES` oldest entries downstream. The consumer may take any prefix of them. A branch or exception redirect flushes the whole queue in one cycle.

---
 rtl/stage_queue.sv | 122 ++++++++++++
 tb/tb_stage_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_queue.sv
// Multi-lane decoupling queue: compacts up to LANES pushes per cycle and presents the oldest LANES entries.
// Optional same-cycle bypass through an empty queue is enabled by defining STAGE_QUEUE_BYPASS_EN.
module stage_queue #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2,
    parameter int DEPTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic [LANES-1:0]               in_valid_i,
    input  logic [LANES-1:0][DATA_W-1:0]   in_data_i,
    output logic                           in_ready_o,
    output logic [LANES-1:0]               out_valid_o,
    output logic [LANES-1:0][DATA_W-1:0]   out_data_o,
    input  logic [$clog2(LANES+1)-1:0]     out_take_i,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0]              mem_q [DEPTH];
    logic [PTR_W-1:0]               head_q, head_d;
    logic [PTR_W-1:0]               tail_q, tail_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [LANES-1:0][DATA_W-1:0]   compData;
    logic                           bypass;
    logic                           pushOk;
    int                             pushN;
    int                             availN;
    int                             takeN;
    int                             skipN;
    int                             popN;

    // Squeeze the valid input lanes together so they land in consecutive slots.
    always_comb begin
        compData = '0;
        pushN    = 0;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid_i[i]) begin
                for (int k = 0; k < LANES; k++) begin
                    if (k == pushN) begin
                        compData[k] = in_data_i[i];
                    end
                end
                pushN = pushN + 1;
            end
        end
    end

    assign in_ready_o = (DEPTH - int'(count_q)) >= LANES;
    assign pushOk     = in_ready_o && !flush_i;
    assign count_o    = count_q;

    always_comb begin
        out_valid_o = '0;
        out_data_o  = '0;
        availN      = 0;
`ifdef STAGE_QUEUE_BYPASS_EN
        bypass = (count_q == '0) && !flush_i;
`else
        bypass = 1'b0;
`endif
        if (bypass) begin
            availN = pushN;
            for (int i = 0; i < LANES; i++) begin
                out_valid_o[i] = (i < pushN);
                out_data_o[i]  = compData[i];
            end
        end else begin
            availN = (int'(count_q) < LANES) ? int'(count_q) : LANES;
            for (int i = 0; i < LANES; i++) begin
                out_valid_o[i] = (i < int'(count_q));
                out_data_o[i]  = mem_q[head_q + PTR_W'(i)];
            end
        end
        // An over-sized take is clamped to what is actually presented.
        takeN = (int'(out_take_i) > availN) ? availN : int'(out_take_i);
        skipN = bypass ? takeN : 0;
        popN  = bypass ? 0 : takeN;
    end

    always_comb begin
        head_d  = head_q + PTR_W'(popN);
        tail_d  = tail_q;
        count_d = count_q - CNT_W'(popN);
        if (pushOk) begin
            tail_d  = tail_q + PTR_W'(pushN - skipN);
            count_d = count_d + CNT_W'(pushN - skipN);
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; lanes already consumed through the bypass are skipped.
    always_ff @(posedge clk_i) begin
        if (!reset_i && pushOk) begin
            for (int j = 0; j < LANES; j++) begin
                if (j >= skipN && j < pushN) begin
                    mem_q[tail_q + PTR_W'(j - skipN)] <= compData[j];
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_queue.sv
// Directed self-checking bench for stage_queue (DEPTH=8, LANES=2, DATA_W=32).
// Bypass-specific steps run only when STAGE_QUEUE_BYPASS_EN is defined.
module tb_stage_queue;

    logic              clk_i;
    logic              reset_i;
    logic              flush_i;
    logic [1:0]        in_valid_i;
    logic [1:0][31:0]  in_data_i;
    logic              in_ready_o;
    logic [1:0]        out_valid_o;
    logic [1:0][31:0]  out_data_o;
    logic [1:0]        out_take_i;
    logic [3:0]        count_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] model[$];
    logic [31:0] nextVal;

    localparam logic [31:0] A = 32'h0000_00A0;
    localparam logic [31:0] B = 32'h0000_00B0;
    localparam logic [31:0] X = 32'h0000_0058;
    localparam logic [31:0] C = 32'h0000_00C0;
    localparam logic [31:0] D = 32'h0000_00D0;
    localparam logic [31:0] E = 32'h0000_00E0;

    stage_queue #(.DATA_W(32), .LANES(2), .DEPTH(8)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_take_i  (out_take_i),
        .count_o     (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // A consumer taking more lanes than are valid is a protocol error on the bench side.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (int'(out_take_i) <= $countones(out_valid_o)) else begin
                errors++;
                $error("[TB] FAIL take_legal observed=%0d allowed=%0d", out_take_i, $countones(out_valid_o));
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [1:0] take, input logic fl);
        in_valid_i   = v;
        in_data_i[0] = d0;
        in_data_i[1] = d1;
        out_take_i   = take;
        flush_i      = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        applyStimulus(2'b00, '0, '0, 2'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset_count", 64'(count_o), 64'd0);
        checkOutput("reset_valid", 64'(out_valid_o), 64'd0);
        checkOutput("reset_ready", 64'(in_ready_o), 64'd1);
        reset_i = 1'b0;

        $display("[TB] two-lane push");
        applyStimulus(2'b11, A, B, 2'd0, 1'b0);
        tick();
        checkOutput("push2_count", 64'(count_o), 64'd2);
        checkOutput("push2_valid", 64'(out_valid_o), 64'd3);
        checkOutput("push2_lane0", 64'(out_data_o[0]), 64'(A));
        checkOutput("push2_lane1", 64'(out_data_o[1]), 64'(B));
        applyStimulus(2'b00, '0, '0, 2'd2, 1'b0);
        tick();
        checkOutput("drain_count", 64'(count_o), 64'd0);
        checkOutput("drain_valid", 64'(out_valid_o), 64'd0);

        $display("[TB] gap compaction");
        applyStimulus(2'b10, '0, X, 2'd0, 1'b0);
        tick();
        checkOutput("gap_valid", 64'(out_valid_o), 64'd1);
        checkOutput("gap_lane0", 64'(out_data_o[0]), 64'(X));
        checkOutput("gap_count", 64'(count_o), 64'd1);
        applyStimulus(2'b00, '0, '0, 2'd1, 1'b0);
        tick();
        checkOutput("gap_drain", 64'(count_o), 64'd0);

        $display("[TB] fill to full boundary");
        applyStimulus(2'b11, 32'd1, 32'd2, 2'd0, 1'b0);
        tick();
        applyStimulus(2'b11, 32'd3, 32'd4, 2'd0, 1'b0);
        tick();
        applyStimulus(2'b11, 32'd5, 32'd6, 2'd0, 1'b0);
        tick();
        checkOutput("fill6_count", 64'(count_o), 64'd6);
        checkOutput("fill6_ready", 64'(in_ready_o), 64'd1);
        applyStimulus(2'b01, 32'd7, '0, 2'd0, 1'b0);
        tick();
        checkOutput("fill7_count", 64'(count_o), 64'd7);
        checkOutput("fill7_ready", 64'(in_ready_o), 64'd0);
        applyStimulus(2'b11, 32'd8, 32'd9, 2'd0, 1'b0);
        tick();
        checkOutput("held_count", 64'(count_o), 64'd7);
        checkOutput("held_lane0", 64'(out_data_o[0]), 64'd1);
        checkOutput("held_lane1", 64'(out_data_o[1]), 64'd2);
        applyStimulus(2'b00, '0, '0, 2'd2, 1'b0);
        tick();
        checkOutput("take2_count", 64'(count_o), 64'd5);
        checkOutput("take2_ready", 64'(in_ready_o), 64'd1);
        checkOutput("take2_lane0", 64'(out_data_o[0]), 64'd3);
        checkOutput("take2_lane1", 64'(out_data_o[1]), 64'd4);

        $display("[TB] flush with concurrent push and take");
        applyStimulus(2'b11, 32'hE1, 32'hE2, 2'd1, 1'b1);
        #1;
        checkOutput("flush_prevalid", 64'(out_valid_o), 64'd3);
        tick();
        checkOutput("flush_count", 64'(count_o), 64'd0);
        checkOutput("flush_valid", 64'(out_valid_o), 64'd0);
        applyStimulus(2'b01, E, '0, 2'd0, 1'b0);
        tick();
        checkOutput("postflush_count", 64'(count_o), 64'd1);
        checkOutput("postflush_lane0", 64'(out_data_o[0]), 64'(E));

        $display("[TB] reset from a partially full queue");
        applyStimulus(2'b11, 32'hF1, 32'hF2, 2'd0, 1'b0);
        tick();
        checkOutput("prereset_count", 64'(count_o), 64'd3);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        applyStimulus(2'b00, '0, '0, 2'd0, 1'b0);
        checkOutput("midreset_count", 64'(count_o), 64'd0);
        checkOutput("midreset_valid", 64'(out_valid_o), 64'd0);
        checkOutput("midreset_ready", 64'(in_ready_o), 64'd1);

        $display("[TB] steady-state wrap");
        applyStimulus(2'b11, 32'd100, 32'd101, 2'd0, 1'b0);
        tick();
        applyStimulus(2'b01, 32'd102, '0, 2'd0, 1'b0);
        tick();
        model = '{32'd100, 32'd101, 32'd102};
        nextVal = 32'd103;
        checkOutput("preload_count", 64'(count_o), 64'd3);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(2'b11, nextVal, nextVal + 32'd1, 2'd2, 1'b0);
            #1;
            checkOutput("wrap_lane0", 64'(out_data_o[0]), 64'(model[0]));
            checkOutput("wrap_lane1", 64'(out_data_o[1]), 64'(model[1]));
            tick();
            void'(model.pop_front());
            void'(model.pop_front());
            model.push_back(nextVal);
            model.push_back(nextVal + 32'd1);
            nextVal = nextVal + 32'd2;
            checkOutput("wrap_count", 64'(count_o), 64'd3);
        end

`ifdef STAGE_QUEUE_BYPASS_EN
        $display("[TB] bypass through empty queue");
        applyStimulus(2'b00, '0, '0, 2'd2, 1'b0);
        tick();
        applyStimulus(2'b00, '0, '0, 2'd1, 1'b0);
        tick();
        checkOutput("bypass_empty", 64'(count_o), 64'd0);
        applyStimulus(2'b11, C, D, 2'd1, 1'b0);
        #1;
        checkOutput("bypass_valid", 64'(out_valid_o), 64'd3);
        checkOutput("bypass_lane0", 64'(out_data_o[0]), 64'(C));
        tick();
        applyStimulus(2'b00, '0, '0, 2'd0, 1'b0);
        checkOutput("bypass_count", 64'(count_o), 64'd1);
        checkOutput("bypass_next", 64'(out_data_o[0]), 64'(D));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
